// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

  typedef logic [31:0] vaddr_t;
  typedef logic [31:0] paddr_t;

  typedef enum logic [1:0] {
    MSIZE1     = 2'd0,
    MSIZE2     = 2'd1,
    MSIZE4     = 2'd2,
    MSIZE_RSVD = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } mau_state_t;

  function automatic logic is_misaligned(input msize_t size, input logic [1:0] off);
    logic bad;
    case (size)
      MSIZE1:  bad = 1'b0;
      MSIZE2:  bad = off[0];
      MSIZE4:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic is_kseg1(input vaddr_t va);
    return (va[31:29] == 3'b101);
  endfunction

endpackage

// File: rtl/address_translator.sv
// Fixed-mapping virtual-to-physical translation: kseg0/kseg1 drop the top
// three bits, every other segment passes through unchanged.
module AddressTranslator
  import mem_access_unit_pkg::*;
(
  input  vaddr_t vaddr,
  output paddr_t paddr
);

  always_comb begin
    if (vaddr[31:30] == 2'b10) begin
      paddr = {3'b000, vaddr[28:0]};
    end else begin
      paddr = vaddr;
    end
  end

endmodule

// File: rtl/mem_access_unit_align.sv
// Combinational byte-lane handling: store strobe/data replication and
// load extraction with sign or zero extension.
module mem_data_align
  import mem_access_unit_pkg::*;
(
  input  msize_t      size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strobe,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [3:0]  strobe_raw;
  logic [31:0] shifted;

  always_comb begin
    strobe_raw = 4'b1111;
    wdata_rep  = wdata;
    load_data  = shifted;
    shifted    = rdata >> {offset, 3'b000};
    case (size)
      MSIZE1: begin
        strobe_raw = 4'b0001 << offset;
        wdata_rep  = {4{wdata[7:0]}};
        load_data  = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      MSIZE2: begin
        strobe_raw = 4'b0011 << offset;
        wdata_rep  = {2{wdata[15:0]}};
        load_data  = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        strobe_raw = 4'b1111;
        wdata_rep  = wdata;
        load_data  = shifted;
      end
    endcase
    strobe = write ? strobe_raw : 4'b0000;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: translates the request address, runs one bus
// transaction at a time and stalls the pipeline until the response returns.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_vaddr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_error,
  output logic        bus_req_valid,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_strobe,
  output logic [31:0] bus_wdata,
  output logic        bus_uncached,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  mau_state_t  state_q, state_d;
  paddr_t      req_paddr;
  paddr_t      paddr_q;
  logic        uncached_q;
  logic        write_q;
  msize_t      size_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        aligned;
  logic        accept;
  logic        capture;
  logic [31:0] load_data;

  AddressTranslator u_xlate (
    .vaddr (req_vaddr),
    .paddr (req_paddr)
  );

  mem_data_align u_align (
    .size      (size_q),
    .offset    (paddr_q[1:0]),
    .is_signed (signed_q),
    .write     (write_q),
    .wdata     (wdata_q),
    .rdata     (bus_rdata),
    .strobe    (bus_strobe),
    .wdata_rep (bus_wdata),
    .load_data (load_data)
  );

  assign aligned = ~is_misaligned(msize_t'(req_size), req_vaddr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      paddr_q    <= '0;
      uncached_q <= 1'b0;
      write_q    <= 1'b0;
      size_q     <= MSIZE1;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        paddr_q    <= req_paddr;
        uncached_q <= is_kseg1(req_vaddr);
        write_q    <= req_write;
        size_q     <= msize_t'(req_size);
        signed_q   <= req_signed;
        wdata_q    <= req_write ? req_wdata : '0;
      end
      if (capture) begin
        rdata_q <= write_q ? '0 : load_data;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    resp_valid    = 1'b0;
    addr_error    = 1'b0;
    bus_req_valid = 1'b0;
    accept        = 1'b0;
    capture       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Outputs must read 0 while reset is held, even if req_valid is high.
        if (req_valid && !reset) begin
          if (aligned) begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_d = S_ADDR;
          end else begin
            addr_error = 1'b1;
          end
        end
      end
      S_ADDR: begin
        bus_req_valid = 1'b1;
        stall         = 1'b1;
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        stall = 1'b1;
        if (bus_data_ok) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_addr     = paddr_q;
  assign bus_write    = write_q;
  assign bus_size     = size_q;
  assign bus_uncached = uncached_q;
  assign resp_rdata   = (state_q == S_DONE) ? rdata_q : '0;

endmodule
